prog_seq: RTL and testbench
===========================

PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 Parameter W, default 8: program-counter width in bits.
REQ-002 Parameter OW, default 6: branch-offset width in bits (OW <= W).
REQ-003 Parameter D, default 4: return-stack depth in entries (D >= 2).
REQ-004 Port Clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 Port Reset_n  in  1: synchronous, active-low reset, sampled on rising Clk.
REQ-006 Port Stall  in  1: hold all state this cycle.
REQ-007 Port BranchEn  in  1: relative-branch request.
REQ-008 Port CondMode  in  2: branch condition (00 always, 01 if Zero=1, 10 if Zero=0, 11 never).
REQ-009 Port Zero  in  1: condition flag from ALU.
REQ-010 Port Dir  in  1: branch direction (0 = forward PC+Offset, 1 = backward PC-Offset).
REQ-011 Port Offset  in  OW: unsigned branch magnitude, zero-extended to W.
REQ-012 Port Call  in  1: absolute call request.
REQ-013 Port Ret  in  1: return request.
REQ-014 Port Target  in  W: absolute call destination.
REQ-015 Port ClrErr  in  1: clears sticky error flags.
REQ-016 Port PC  out  W: registered program counter.
REQ-017 Port Depth  out  $clog2(D+1): registered count of valid stack entries.
REQ-018 Port Taken  out  1: combinational, 1 when the current inputs redirect PC (taken branch, accepted call, accepted return).
REQ-019 Port Overflow  out  1: sticky, set on a call while the stack is full.
REQ-020 Port Underflow  out  1: sticky, set on a return while the stack is empty.

Function
REQ-021 Action priority per cycle SHALL be: reset > Stall > Ret > Call > BranchEn > increment.
REQ-022 Stall=1 SHALL hold PC, stack, Depth, and flags; ClrErr is ignored; Taken SHALL be 0.
REQ-023 Increment: PC <= PC+1 modulo 2^W (all-ones wraps to 0).
REQ-024 Branch taken (BranchEn=1 and condition per CondMode true) SHALL set PC <= PC +/- zero-extended Offset modulo 2^W, with the sign selected by Dir.
REQ-025 Branch not taken SHALL be an increment; Offset=0 taken SHALL hold PC (self-loop).
REQ-026 Call with Depth<D SHALL push PC+1 (mod 2^W), set PC <= Target, and increment Depth.
REQ-027 Call with Depth=D SHALL NOT push; PC SHALL increment; Overflow SHALL be set; Taken SHALL be 0.
REQ-028 Ret with Depth>0 SHALL pop the top entry into PC and decrement Depth (LIFO).
REQ-029 Ret with Depth=0 SHALL increment PC; Underflow SHALL be set; Taken SHALL be 0.
REQ-030 Ret and Call asserted together SHALL perform only the return; the call is dropped without setting a flag.
REQ-031 Call or Ret together with BranchEn SHALL ignore the branch entirely.
REQ-032 ClrErr=1 SHALL clear both flags; a same-cycle overflow or underflow event SHALL win (flag ends set).
REQ-033 Stack storage SHALL be D x W registers indexed by Depth; popped entries need not be cleared.
REQ-034 Changes to PC, Depth, and flags SHALL be visible in the cycle after the qualifying edge (latency 1).

Reset
REQ-035 Reset_n=0 at a rising edge SHALL set PC=0, Depth=0, Overflow=0, Underflow=0, regardless of Stall, Call, Ret, or BranchEn.
REQ-036 Reset SHALL be honoured mid-call or mid-return; stack contents after reset are don't-care, since Depth=0.
REQ-037 Taken SHALL be forced to 0 while Reset_n=0.

Verification (W=8, OW=6, D=4)
REQ-038 Reset, then 3 idle cycles -> PC sequence 0,1,2,3; Depth=0; flags=0.
REQ-039 PC=0x10, BranchEn, CondMode=01, Zero=1, Dir=1, Offset=5 -> PC=0x0B; repeat with Zero=0 -> PC=0x0C.
REQ-040 PC=0xFE, increment twice -> 0xFF, 0x00; PC=0x02, backward Offset=4 -> 0xFE.
REQ-041 PC=0x20, Call Target=0x80 -> PC=0x80, Depth=1; next cycle Ret -> PC=0x21, Depth=0.
REQ-042 Four nested calls from PCs 0x01, 0x11, 0x21, 0x31, then a fifth call -> Overflow=1, Depth=4, PC increments; four returns yield 0x32, 0x22, 0x12, 0x02; a fifth Ret -> Underflow=1.
REQ-043 Stall held 3 cycles during a Call -> PC, Depth unchanged and Taken=0; Reset_n=0 with Call=1 -> PC=0, Depth=0.

Source files
------------

// File: rtl/prog_seq.sv
// Program sequencer: PC with relative branches, absolute calls and a
// small hardware return stack with sticky overflow/underflow flags.
module prog_seq #(
   parameter int W  = 8,
   parameter int OW = 6,
   parameter int D  = 4
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     Stall,
   input  logic                     BranchEn,
   input  logic [1:0]               CondMode,
   input  logic                     Zero,
   input  logic                     Dir,
   input  logic [OW-1:0]            Offset,
   input  logic                     Call,
   input  logic                     Ret,
   input  logic [W-1:0]             Target,
   input  logic                     ClrErr,
   output logic [W-1:0]             PC,
   output logic [$clog2(D+1)-1:0]   Depth,
   output logic                     Taken,
   output logic                     Overflow,
   output logic                     Underflow
);

   localparam int DW = $clog2(D+1);
   localparam int IW = $clog2(D);

   logic [W-1:0]  stack [D];
   logic          cond;
   logic          full;
   logic          empty;
   logic          ret_ok;
   logic          call_ok;
   logic          br_take;
   logic [W-1:0]  pc_inc;
   logic [W-1:0]  off;
   logic [W-1:0]  br_pc;
   logic [IW-1:0] push_idx;
   logic [IW-1:0] pop_idx;

   always_comb begin
      cond = 1'b0;
      unique case (CondMode)
         2'b00:   cond = 1'b1;
         2'b01:   cond = Zero;
         2'b10:   cond = ~Zero;
         default: cond = 1'b0;
      endcase
   end

   assign full  = (Depth == DW'(D));
   assign empty = (Depth == '0);

   // Ret outranks Call, and either one suppresses the branch
   assign ret_ok  = Ret & ~empty;
   assign call_ok = Call & ~Ret & ~full;
   assign br_take = BranchEn & ~Ret & ~Call & cond;

   assign Taken = Reset_n & ~Stall & (ret_ok | call_ok | br_take);

   assign pc_inc   = PC + W'(1);
   assign off      = W'(Offset);
   assign br_pc    = Dir ? (PC - off) : (PC + off);
   assign push_idx = IW'(Depth);
   assign pop_idx  = IW'(Depth - DW'(1));

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         PC        <= '0;
         Depth     <= '0;
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else if (!Stall) begin
         if (ret_ok) begin
            PC    <= stack[pop_idx];
            Depth <= Depth - DW'(1);
         end else if (call_ok) begin
            stack[push_idx] <= pc_inc;
            PC              <= Target;
            Depth           <= Depth + DW'(1);
         end else if (br_take) begin
            PC <= br_pc;
         end else begin
            PC <= pc_inc;
         end
         // a same-cycle error event beats the clear
         Overflow  <= (Call & ~Ret & full) | (Overflow & ~ClrErr);
         Underflow <= (Ret & empty) | (Underflow & ~ClrErr);
      end
   end

endmodule

// File: tb/tb_prog_seq.sv
// Directed bench for prog_seq (W=8, OW=6, D=4) with hand-computed
// expected values.
module tb_prog_seq;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Stall;
   logic       BranchEn;
   logic [1:0] CondMode;
   logic       Zero;
   logic       Dir;
   logic [5:0] Offset;
   logic       Call;
   logic       Ret;
   logic [7:0] Target;
   logic       ClrErr;
   logic [7:0] PC;
   logic [2:0] Depth;
   logic       Taken;
   logic       Overflow;
   logic       Underflow;

   int n_chk  = 0;
   int n_pass = 0;

   prog_seq #(.W(8), .OW(6), .D(4)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Stall     (Stall),
      .BranchEn  (BranchEn),
      .CondMode  (CondMode),
      .Zero      (Zero),
      .Dir       (Dir),
      .Offset    (Offset),
      .Call      (Call),
      .Ret       (Ret),
      .Target    (Target),
      .ClrErr    (ClrErr),
      .PC        (PC),
      .Depth     (Depth),
      .Taken     (Taken),
      .Overflow  (Overflow),
      .Underflow (Underflow)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      Stall = 0; BranchEn = 0; CondMode = 2'b00; Zero = 0; Dir = 0;
      Offset = '0; Call = 0; Ret = 0; Target = '0; ClrErr = 0;
   endtask

   task automatic branch(input logic [1:0] cm, input logic z,
                         input logic d, input logic [5:0] o);
      BranchEn = 1; CondMode = cm; Zero = z; Dir = d; Offset = o;
   endtask

   task automatic do_call(input logic [7:0] t);
      Call = 1; Target = t;
   endtask

   initial begin
      idle();
      // reset while a call is requested
      Reset_n = 0;
      do_call(8'h55);
      #1;
      chk("taken_in_reset", Taken, 0);
      step(); step();
      chk("rst_pc", PC, 8'h00);
      chk("rst_depth", Depth, 0);
      chk("rst_ovf", Overflow, 0);
      chk("rst_unf", Underflow, 0);
      Reset_n = 1; idle();
      step(); chk("inc1", PC, 8'h01);
      step(); chk("inc2", PC, 8'h02);
      step(); chk("inc3", PC, 8'h03);

      // branches
      branch(2'b00, 0, 0, 6'd13); #1;
      chk("br_fwd_taken", Taken, 1);
      step(); chk("br_fwd", PC, 8'h10);
      branch(2'b01, 1, 1, 6'd5); #1;
      chk("br_z1_taken", Taken, 1);
      step(); chk("br_back", PC, 8'h0B);
      branch(2'b01, 0, 1, 6'd5); #1;
      chk("br_z0_taken", Taken, 0);
      step(); chk("br_not", PC, 8'h0C);
      branch(2'b10, 0, 1, 6'd14);
      step(); chk("br_wrap_back", PC, 8'hFE);
      idle();
      step(); chk("inc_ff", PC, 8'hFF);
      step(); chk("inc_wrap", PC, 8'h00);
      step(); step(); chk("inc_02", PC, 8'h02);
      branch(2'b00, 0, 1, 6'd4);
      step(); chk("br_back4", PC, 8'hFE);
      branch(2'b11, 0, 0, 6'd7); #1;
      chk("never_taken", Taken, 0);
      step(); chk("br_never", PC, 8'hFF);
      branch(2'b00, 0, 0, 6'd0); #1;
      chk("self_taken", Taken, 1);
      step(); chk("br_self", PC, 8'hFF);
      idle();
      step(); chk("inc_00", PC, 8'h00);
      branch(2'b00, 0, 0, 6'd32);
      step(); chk("to_20", PC, 8'h20);

      // single call/return
      idle(); do_call(8'h80); #1;
      chk("call_taken", Taken, 1);
      step(); chk("call_pc", PC, 8'h80);
      chk("call_depth", Depth, 1);
      idle(); Ret = 1; #1;
      chk("ret_taken", Taken, 1);
      step(); chk("ret_pc", PC, 8'h21);
      chk("ret_depth", Depth, 0);

      // nested calls to overflow
      idle(); branch(2'b00, 0, 1, 6'd32);
      step(); chk("to_01", PC, 8'h01);
      idle(); do_call(8'h11); step();
      do_call(8'h21); step();
      do_call(8'h31); step();
      chk("nest_pc31", PC, 8'h31);
      do_call(8'h40); BranchEn = 1; step();
      chk("nest_depth4", Depth, 4);
      chk("nest_pc40", PC, 8'h40);
      do_call(8'h99); #1;
      chk("ovf_taken", Taken, 0);
      step();
      chk("ovf_flag", Overflow, 1);
      chk("ovf_depth", Depth, 4);
      chk("ovf_pc", PC, 8'h41);

      // returns; first with Call and branch also asserted
      idle(); Ret = 1; do_call(8'h77); branch(2'b00, 0, 0, 6'd9);
      step(); chk("pop1", PC, 8'h32);
      chk("pop1_depth", Depth, 3);
      chk("pop1_ovf", Overflow, 1);
      idle(); Ret = 1; ClrErr = 1;
      step(); chk("pop2", PC, 8'h22);
      chk("clr_ovf", Overflow, 0);
      idle(); Ret = 1;
      step(); chk("pop3", PC, 8'h12);
      step(); chk("pop4", PC, 8'h02);
      chk("pop4_depth", Depth, 0);
      #1; chk("unf_taken", Taken, 0);
      step(); chk("unf_flag", Underflow, 1);
      chk("unf_pc", PC, 8'h03);
      ClrErr = 1;
      step(); chk("unf_wins_clr", Underflow, 1);
      chk("unf_pc2", PC, 8'h04);
      idle(); ClrErr = 1;
      step(); chk("clr_unf", Underflow, 0);
      chk("clr_pc", PC, 8'h05);

      // stall during a call, with ClrErr ignored
      idle(); Ret = 1; step();
      chk("unf_again", Underflow, 1);
      idle(); Stall = 1; do_call(8'h70); ClrErr = 1;
      for (int i = 0; i < 3; i++) begin
         #1; chk("stall_taken", Taken, 0);
         step();
         chk("stall_pc", PC, 8'h06);
         chk("stall_depth", Depth, 0);
         chk("stall_unf", Underflow, 1);
      end
      Stall = 0; ClrErr = 0;
      step(); chk("post_stall_pc", PC, 8'h70);
      chk("post_stall_depth", Depth, 1);
      Reset_n = 0;
      step(); chk("rst_call_pc", PC, 8'h00);
      chk("rst_call_depth", Depth, 0);
      chk("rst_call_unf", Underflow, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
